// File: rtl/frame_pacer.sv
// Frame pacer: divides one second by a requested frame rate and emits
// frame-start pulses every period, counting ticks lost while the renderer is busy.
module frame_pacer #(
  parameter int unsigned WIDTH             = 32,
  parameter int unsigned ONE_SECOND_CYCLES = 4_000_000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [15:0]      target_fps_in,
  input  logic             target_valid_in,
  output logic             target_ready_out,
  input  logic             enable_in,
  input  logic             frame_done_in,
  output logic             new_frame_out,
  output logic             rendering_out,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] dropped_out,
  output logic             error_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE_SEC  = WIDTH'(ONE_SECOND_CYCLES);
  localparam logic [BW-1:0]    BIT_LAST = BW'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] dropped_q, dropped_d;
  logic             error_q, error_d;
  logic             rendering_q, rendering_d;
  logic             new_frame_q, new_frame_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [15:0]      dsr_q, dsr_d;
  logic [BW-1:0]    bit_q, bit_d;

  logic             accept;
  logic             tick;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    dropped_d   = dropped_q;
    error_d     = error_q;
    rendering_d = rendering_q;
    new_frame_d = 1'b0;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    bit_d       = bit_q;
    tick        = 1'b0;

    accept    = target_valid_in && (state_q != S_DIVIDE);
    // dvd_q shifts the dividend out of its top while quotient bits enter at the bottom
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    rem_ge    = rem_shift >= (WIDTH+1)'(dsr_q);
    rem_sub   = rem_shift[WIDTH-1:0] - WIDTH'(dsr_q);

    case (state_q)
      S_IDLE, S_RUN: begin
        if (accept) begin
          state_d     = S_DIVIDE;
          cnt_d       = '0;
          rendering_d = 1'b0;
          dropped_d   = '0;
          dvd_d       = ONE_SEC;
          rem_d       = '0;
          dsr_d       = target_fps_in;
          bit_d       = '0;
        end else begin
          if (state_q == S_RUN && enable_in) begin
            tick  = (cnt_q == period_q - WIDTH'(1));
            cnt_d = tick ? '0 : cnt_q + WIDTH'(1);
          end
          // A done arriving on the tick frees the renderer before the tick is judged
          if (tick && (!rendering_q || frame_done_in)) begin
            new_frame_d = 1'b1;
            rendering_d = 1'b1;
          end else if (tick) begin
            if (dropped_q != '1) dropped_d = dropped_q + WIDTH'(1);
          end else if (frame_done_in) begin
            rendering_d = 1'b0;
          end
        end
      end
      S_DIVIDE: begin
        if (bit_q == BIT_LAST) begin
          if (dsr_q == '0 || dvd_q == '0) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            period_d = dvd_q;
            error_d  = 1'b0;
            state_d  = S_RUN;
          end
        end else begin
          rem_d = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], rem_ge};
          bit_d = bit_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      dropped_q   <= '0;
      error_q     <= 1'b0;
      rendering_q <= 1'b0;
      new_frame_q <= 1'b0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      bit_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      dropped_q   <= dropped_d;
      error_q     <= error_d;
      rendering_q <= rendering_d;
      new_frame_q <= new_frame_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      bit_q       <= bit_d;
    end
  end

  assign target_ready_out = (state_q != S_DIVIDE);
  assign new_frame_out    = new_frame_q;
  assign rendering_out    = rendering_q;
  assign period_out       = period_q;
  assign dropped_out      = dropped_q;
  assign error_out        = error_q;

endmodule

// File: tb/tb_frame_pacer.sv
// Directed bench for frame_pacer with a 100-cycle "second" so periods stay short.
module tb_frame_pacer;

  localparam int unsigned WIDTH = 32;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [15:0]      target_fps_in;
  logic             target_valid_in;
  logic             target_ready_out;
  logic             enable_in;
  logic             frame_done_in;
  logic             new_frame_out;
  logic             rendering_out;
  logic [WIDTH-1:0] period_out;
  logic [WIDTH-1:0] dropped_out;
  logic             error_out;

  int checks   = 0;
  int failures = 0;

  frame_pacer #(.WIDTH(WIDTH), .ONE_SECOND_CYCLES(100)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .target_fps_in    (target_fps_in),
    .target_valid_in  (target_valid_in),
    .target_ready_out (target_ready_out),
    .enable_in        (enable_in),
    .frame_done_in    (frame_done_in),
    .new_frame_out    (new_frame_out),
    .rendering_out    (rendering_out),
    .period_out       (period_out),
    .dropped_out      (dropped_out),
    .error_out        (error_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic accept(input logic [15:0] t);
    target_fps_in   = t;
    target_valid_in = 1'b1;
    step();
    target_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    step();
    step();
    checks++; if (new_frame_out !== 1'b0) begin failures++; $display("FAIL reset_new_frame: got %0d want 0", new_frame_out); end
    checks++; if (rendering_out !== 1'b0) begin failures++; $display("FAIL reset_rendering: got %0d want 0", rendering_out); end
    checks++; if (period_out !== 32'd0) begin failures++; $display("FAIL reset_period: got %0d want 0", period_out); end
    checks++; if (dropped_out !== 32'd0) begin failures++; $display("FAIL reset_dropped: got %0d want 0", dropped_out); end
    checks++; if (error_out !== 1'b0) begin failures++; $display("FAIL reset_error: got %0d want 0", error_out); end
    checks++; if (target_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0d want 1", target_ready_out); end
    rst_in = 1'b1;
  endtask

  task automatic test_basic_pacing();
    logic prev;
    enable_in     = 1'b1;
    frame_done_in = 1'b0;
    accept(16'd25);
    // a competing offer during the divide must be dropped
    target_fps_in   = 16'd50;
    target_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    target_valid_in = 1'b0;
    checks++; if (target_ready_out !== 1'b0) begin failures++; $display("FAIL divide_ready: got %0d want 0", target_ready_out); end
    for (int i = 0; i < 27; i++) step();
    checks++; if (period_out !== 32'd0) begin failures++; $display("FAIL period_before_33: got %0d want 0", period_out); end
    step();
    checks++; if (period_out !== 32'd4) begin failures++; $display("FAIL period_at_33: got %0d want 4", period_out); end
    checks++; if (error_out !== 1'b0) begin failures++; $display("FAIL basic_error: got %0d want 0", error_out); end
    checks++; if (target_ready_out !== 1'b1) begin failures++; $display("FAIL run_ready: got %0d want 1", target_ready_out); end
    prev = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      frame_done_in = prev;
      step();
      checks++;
      if (new_frame_out !== ((i % 4) == 0)) begin
        failures++;
        $display("FAIL basic_pulse_cycle%0d: got %0d want %0d", i, new_frame_out, (i % 4) == 0);
      end
      prev = new_frame_out;
    end
    frame_done_in = 1'b0;
    checks++; if (dropped_out !== 32'd0) begin failures++; $display("FAIL basic_dropped: got %0d want 0", dropped_out); end
  endtask

  task automatic test_invalid_target();
    int pulses;
    logic [15:0] bad [2];
    bad[0] = 16'd0;
    bad[1] = 16'd200;
    for (int k = 0; k < 2; k++) begin
      pulses = 0;
      accept(bad[k]);
      for (int i = 0; i < 41; i++) begin
        step();
        if (new_frame_out) pulses++;
      end
      checks++; if (error_out !== 1'b1) begin failures++; $display("FAIL invalid%0d_error: got %0d want 1", bad[k], error_out); end
      checks++; if (period_out !== 32'd4) begin failures++; $display("FAIL invalid%0d_period: got %0d want 4", bad[k], period_out); end
      checks++; if (target_ready_out !== 1'b1) begin failures++; $display("FAIL invalid%0d_ready: got %0d want 1", bad[k], target_ready_out); end
      checks++; if (pulses !== 0) begin failures++; $display("FAIL invalid%0d_pulses: got %0d want 0", bad[k], pulses); end
    end
    accept(16'd50);
    for (int i = 0; i < 33; i++) step();
    checks++; if (period_out !== 32'd2) begin failures++; $display("FAIL recover_period: got %0d want 2", period_out); end
    checks++; if (error_out !== 1'b0) begin failures++; $display("FAIL recover_error: got %0d want 0", error_out); end
  endtask

  task automatic test_drop();
    int pulses;
    frame_done_in = 1'b0;
    accept(16'd25);
    for (int i = 0; i < 33; i++) step();
    checks++; if (period_out !== 32'd4) begin failures++; $display("FAIL drop_period: got %0d want 4", period_out); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (new_frame_out) pulses++;
    end
    step();
    checks++; if (new_frame_out !== 1'b1) begin failures++; $display("FAIL drop_first_pulse: got %0d want 1", new_frame_out); end
    for (int i = 0; i < 12; i++) begin
      step();
      if (new_frame_out) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL drop_extra_pulses: got %0d want 0", pulses); end
    checks++; if (dropped_out !== 32'd3) begin failures++; $display("FAIL drop_count: got %0d want 3", dropped_out); end
    checks++; if (rendering_out !== 1'b1) begin failures++; $display("FAIL drop_rendering: got %0d want 1", rendering_out); end
  endtask

  task automatic test_done_on_tick();
    for (int i = 0; i < 3; i++) step();
    frame_done_in = 1'b1;
    step();
    frame_done_in = 1'b0;
    checks++; if (new_frame_out !== 1'b1) begin failures++; $display("FAIL tick_done_pulse: got %0d want 1", new_frame_out); end
    checks++; if (dropped_out !== 32'd3) begin failures++; $display("FAIL tick_done_dropped: got %0d want 3", dropped_out); end
    checks++; if (rendering_out !== 1'b1) begin failures++; $display("FAIL tick_done_rendering: got %0d want 1", rendering_out); end
  endtask

  task automatic test_enable_gap();
    int pulses;
    accept(16'd25);
    for (int i = 0; i < 33; i++) step();
    for (int i = 0; i < 4; i++) step();
    checks++; if (new_frame_out !== 1'b1) begin failures++; $display("FAIL gap_first_pulse: got %0d want 1", new_frame_out); end
    step();
    step();
    enable_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      frame_done_in = (i == 4);
      step();
      if (new_frame_out) pulses++;
    end
    frame_done_in = 1'b0;
    checks++; if (pulses !== 0) begin failures++; $display("FAIL gap_pulses: got %0d want 0", pulses); end
    checks++; if (rendering_out !== 1'b0) begin failures++; $display("FAIL gap_rendering: got %0d want 0", rendering_out); end
    enable_in = 1'b1;
    step();
    checks++; if (new_frame_out !== 1'b0) begin failures++; $display("FAIL gap_reenable1: got %0d want 0", new_frame_out); end
    step();
    checks++; if (new_frame_out !== 1'b1) begin failures++; $display("FAIL gap_reenable2: got %0d want 1", new_frame_out); end
    checks++; if (dropped_out !== 32'd0) begin failures++; $display("FAIL gap_dropped: got %0d want 0", dropped_out); end
  endtask

  task automatic test_period_one();
    accept(16'd100);
    for (int i = 0; i < 33; i++) step();
    checks++; if (period_out !== 32'd1) begin failures++; $display("FAIL p1_period: got %0d want 1", period_out); end
    frame_done_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (new_frame_out !== 1'b1) begin failures++; $display("FAIL p1_pulse%0d: got %0d want 1", i, new_frame_out); end
    end
    frame_done_in = 1'b0;
    step();
    checks++; if (new_frame_out !== 1'b0) begin failures++; $display("FAIL p1_busy_pulse: got %0d want 0", new_frame_out); end
    checks++; if (dropped_out !== 32'd1) begin failures++; $display("FAIL p1_dropped: got %0d want 1", dropped_out); end
  endtask

  task automatic test_reset_mid_divide();
    int pulses;
    accept(16'd25);
    for (int i = 0; i < 10; i++) step();
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    checks++; if (period_out !== 32'd0) begin failures++; $display("FAIL mid_rst_period: got %0d want 0", period_out); end
    checks++; if (dropped_out !== 32'd0) begin failures++; $display("FAIL mid_rst_dropped: got %0d want 0", dropped_out); end
    checks++; if (error_out !== 1'b0) begin failures++; $display("FAIL mid_rst_error: got %0d want 0", error_out); end
    checks++; if (rendering_out !== 1'b0) begin failures++; $display("FAIL mid_rst_rendering: got %0d want 0", rendering_out); end
    checks++; if (target_ready_out !== 1'b1) begin failures++; $display("FAIL mid_rst_ready: got %0d want 1", target_ready_out); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (new_frame_out) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL mid_rst_pulses: got %0d want 0", pulses); end
    checks++; if (period_out !== 32'd0) begin failures++; $display("FAIL mid_rst_period_late: got %0d want 0", period_out); end
  endtask

  initial begin
    rst_in          = 1'b0;
    target_fps_in   = '0;
    target_valid_in = 1'b0;
    enable_in       = 1'b0;
    frame_done_in   = 1'b0;
    test_reset();
    test_basic_pacing();
    test_invalid_target();
    test_drop();
    test_done_on_tick();
    test_enable_gap();
    test_period_one();
    test_reset_mid_divide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/frame_pacer.md
FRAME_PACER -- requirements
Module: frame_pacer

Interface
REQ-001 Parameter WIDTH, default 32: width of period, counter and dropped-frame registers.
REQ-002 Parameter ONE_SECOND_CYCLES, default 4_000_000: clock cycles per second.
REQ-003 Port clk_in  input  1: sole clock; all logic on its rising edge.
REQ-004 Port rst_in  input  1: one clock; reset is synchronous and active-low (rst_in low = reset).
REQ-005 Port target_fps_in  input  16: requested frames per second.
REQ-006 Port target_valid_in  input  1: target offer; accepted on a cycle with target_valid_in && target_ready_out.
REQ-007 Port target_ready_out  output  1: high in IDLE and RUN, low in DIVIDE.
REQ-008 Port enable_in  input  1: frame tick generation enabled when high.
REQ-009 Port frame_done_in  input  1: one-cycle pulse from renderer; current frame finished.
REQ-010 Port new_frame_out  output  1: one-cycle frame-start pulse to renderer and fps_counter.
REQ-011 Port rendering_out  output  1: high from a new_frame_out pulse until frame_done_in.
REQ-012 Port period_out  output  WIDTH: active frame period in cycles.
REQ-013 Port dropped_out  output  WIDTH: ticks that fell while rendering_out was high.
REQ-014 Port error_out  output  1: last accepted target was invalid.

Function
REQ-015 The FSM SHALL have states IDLE, DIVIDE and RUN.
REQ-016 Target accept in IDLE or RUN SHALL go to DIVIDE and clear the tick counter, rendering_out and dropped_out.
REQ-017 DIVIDE SHALL compute ONE_SECOND_CYCLES / target_fps_in by restoring shift-subtract, one quotient bit per cycle, leaving DIVIDE exactly WIDTH+1 cycles after accept.
REQ-018 A quotient >= 1 SHALL load period_out, clear error_out and enter RUN.
REQ-019 Target 0 or quotient 0 (target > ONE_SECOND_CYCLES) SHALL set error_out=1, leave period_out unchanged and enter IDLE.
REQ-020 target_valid_in during DIVIDE SHALL be ignored; no result is queued.
REQ-021 In IDLE and DIVIDE, new_frame_out SHALL be 0.
REQ-022 In RUN with enable_in high, the tick counter SHALL increment each cycle and wrap to 0 after reaching period_out-1; the wrap cycle is a tick.
REQ-023 With enable_in low in RUN, the counter SHALL hold and no tick SHALL occur; rendering_out and dropped_out still respond to frame_done_in.
REQ-024 The first tick SHALL be on the period_out-th enabled RUN cycle; later ticks every period_out enabled cycles.
REQ-025 new_frame_out SHALL be registered, high in the cycle after a tick only when rendering_out is 0 (or cleared in the tick cycle), and set rendering_out.
REQ-026 A tick with rendering_out high and no frame_done_in SHALL emit no pulse and increment dropped_out, saturating at all-ones.
REQ-027 frame_done_in coinciding with a tick SHALL count as done first: pulse emitted, dropped_out unchanged.
REQ-028 frame_done_in while rendering_out is 0 SHALL be ignored.
REQ-029 period_out = 1 SHALL give a tick every enabled cycle.

Reset
REQ-030 While rst_in is low: state IDLE, counter 0, new_frame_out 0, rendering_out 0, period_out 0, dropped_out 0, error_out 0, target_ready_out 1 from the next cycle.
REQ-031 Reset SHALL override any operation, including mid-DIVIDE; partial quotient discarded.

Verification (bench ONE_SECOND_CYCLES=100, WIDTH=32)
REQ-032 target 25 accepted, frame_done_in 1 cycle after each pulse -> period_out=4 after 33 cycles; new_frame_out every 4 cycles; dropped_out=0.
REQ-033 target 0 -> error_out=1, state IDLE, no pulses, period_out unchanged; target 200 -> same.
REQ-034 target 25, no frame_done_in -> one pulse; next three ticks produce none; dropped_out=3.
REQ-035 frame_done_in on the tick cycle -> pulse next cycle, dropped_out unchanged.
REQ-036 enable_in low for 10 cycles mid-period at count 2 -> no pulses; next pulse 2 enabled cycles after re-enable.
REQ-037 rst_in low 1 cycle during DIVIDE -> all outputs 0, target_ready_out=1, no pulse afterwards.
